pdm_mic_ctrl: RTL and testbench
===============================

# pdm_mic_ctrl

Sequencing and gain controller for the PDM microphone capture chain. It powers up the microphone, holds the CIC3 decimator in reset until the microphone clock is stable, and discards start-up transients. It adjusts the decimator's `scale_shift` with a windowed peak-detect AGC and delivers PCM samples to downstream logic through a 2-entry valid/ready FIFO. All logic is in the `clk` domain, the same clock that drives the decimator.

## Interface
- `WAKE_CYCLES`, 1000: clocks spent in WAKE before the decimator leaves reset.
- `SETTLE_SAMPLES`, 16: decimator samples discarded after wake.
- `SHIFT_BLANK`, 4: samples discarded after every AGC shift change.
- `AGC_WINDOW`, 256: samples per AGC evaluation window (power of 2, ≥4).
- `HI_THRESH`, 24576: peak strictly above this value triggers a shift increment.
- `LO_THRESH`, 4096: peak strictly below this value triggers a shift decrement.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: capture request. Level sensitive.
- `agc_en` in 1: 1 = AGC active; 0 = shift frozen at its current value.
- `init_shift` in 3: shift loaded on OFF→WAKE.
- `mic_en` out 1: microphone power/clock enable.
- `dec_rst` out 1: decimator reset.
- `dec_scale_shift` out 3: drives the decimator's `scale_shift`.
- `dec_pcm` in 16 signed: decimator output sample.
- `dec_pcm_valid` in 1: decimator sample strobe, 1 cycle.
- `m_tdata` out 16 signed: output sample.
- `m_tvalid` out 1: output valid.
- `m_tready` in 1: downstream ready.
- `overflow` out 1: sticky flag; a sample was dropped because the FIFO was full.
- `state` out 3: OFF=0, WAKE=1, SETTLE=2, RUN=3, BLANK=4.

## Operation
- **Reset values:** state OFF, `mic_en`=0, `dec_rst`=1, `dec_scale_shift`=0, FIFO empty, `m_tvalid`=0, `m_tdata`=0, `overflow`=0.
- **OFF:**
  - Outputs: `mic_en`=0, `dec_rst`=1, FIFO flushed, `overflow` cleared.
  - `enable`=1 → WAKE. On this transition `dec_scale_shift` ← `init_shift` and the wake counter is cleared.
- **WAKE:**
  - Outputs: `mic_en`=1, `dec_rst`=1.
  - Counts clocks; after exactly `WAKE_CYCLES` clocks in WAKE → SETTLE, with the sample counter cleared.
- **SETTLE:**
  - Outputs: `mic_en`=1, `dec_rst`=0.
  - Each `dec_pcm_valid` is discarded and counted. On the `SETTLE_SAMPLES`-th discard → RUN.
- **RUN:**
  - Each `dec_pcm_valid` is pushed to the FIFO and fed to the AGC.
  - Entry from SETTLE or BLANK clears the window counter and the peak register.
- **BLANK:**
  - Same outputs as RUN. Samples are discarded and counted; the AGC is frozen.
  - After `SHIFT_BLANK` discards → RUN.
- **`enable` low:** from any state except OFF → OFF on the next clock. Samples arriving that cycle are dropped, with no overflow.
- **AGC (RUN only):**
  - Magnitude = |`dec_pcm`|; -32768 saturates to 32767. Peak register = max magnitude seen in the window.
  - Every `dec_pcm_valid` in RUN, including dropped ones, advances the window counter.
  - On the `AGC_WINDOW`-th sample, the decision uses the peak including that sample:
    - `agc_en`=1, peak > `HI_THRESH`, shift<7 → shift+1, then → BLANK.
    - Else if `agc_en`=1, peak < `LO_THRESH`, shift>0 → shift−1, then → BLANK.
    - Otherwise stay in RUN; window and peak are cleared.
  - The shift never wraps: it saturates at 0 and 7.
- **FIFO:**
  - 2 entries, first-in first-out. `m_tdata` = head entry.
  - Pop when `m_tvalid` && `m_tready`.
  - Push while full: accepted only if a pop occurs the same cycle. Otherwise the sample is dropped and `overflow` ← 1.
  - `overflow` is cleared only by `rst` or OFF.
  - `m_tdata` holds its value while `m_tvalid`=0.

## Timing
- `dec_pcm_valid` at cycle t with FIFO empty → `m_tvalid`=1 and `m_tdata`=sample at t+1.
- `m_tvalid` stays stable until a pop, as required by the AXI-S rule.
- `dec_rst` deasserts at the first cycle in SETTLE, which is `WAKE_CYCLES`+1 clocks after `enable` is seen in OFF.
- The shift update and the RUN→BLANK transition are registered together. `dec_scale_shift` changes in the same cycle that `state` shows BLANK, one clock after the deciding sample.
- Simultaneous push and pop with 1 entry: the count stays 1, the head becomes the new sample, and `m_tvalid` stays 1.
- `rst` has priority over every event, including mid-window and with a non-empty FIFO.

## Test plan
- **Start-up:** `rst` for 2 clocks, `enable`=1, `init_shift`=3, decimator producing samples → `dec_rst`=1 for 1001 clocks after `enable`; first 16 samples absent from `m_tdata`; sample 17 output; `dec_scale_shift`=3 throughout.
- **AGC up:** RUN, `agc_en`=1, shift=2, 256 samples with one value -30000 → after sample 256, shift=3 and state=BLANK; next 4 samples discarded; sample 5 output; state=RUN.
- **AGC limits:**
  - Shift=0 with all samples equal to 100 → shift stays 0 and there is no BLANK.
  - -32768 input counts as peak 32767; with shift=7 the shift stays 7.
- **Backpressure:** `m_tready`=0, 3 samples in RUN → first 2 held in order; third dropped; `overflow`=1 and stays 1 after `m_tready`=1; cleared after `enable` 0→1.
- **Simultaneous push/pop:** FIFO full, `m_tready`=1 in the same cycle as `dec_pcm_valid` → no drop; `overflow` stays 0; ordering preserved.
- **Abort:** `enable`=0 mid-SETTLE and mid-RUN → next clock state=OFF, `mic_en`=0, `dec_rst`=1, `m_tvalid`=0.

Source files
------------

// File: rtl/pdm_mic_ctrl.sv
// pdm_mic_ctrl: power-up sequencing, start-up transient discard, windowed
// peak-detect AGC on the decimator scale_shift, and a 2-entry valid/ready
// output FIFO for the PDM microphone capture chain. Single clock domain.
module pdm_mic_ctrl #(
  parameter int WAKE_CYCLES    = 1000,
  parameter int SETTLE_SAMPLES = 16,
  parameter int SHIFT_BLANK    = 4,
  parameter int AGC_WINDOW     = 256,
  parameter int HI_THRESH      = 24576,
  parameter int LO_THRESH      = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_agc_en,
  input  logic [2:0]         i_init_shift,
  output logic               o_mic_en,
  output logic               o_dec_rst,
  output logic [2:0]         o_dec_scale_shift,
  input  logic signed [15:0] i_dec_pcm,
  input  logic               i_dec_pcm_valid,
  output logic signed [15:0] o_m_tdata,
  output logic               o_m_tvalid,
  input  logic               i_m_tready,
  output logic               o_overflow,
  output logic [2:0]         o_state
);

  localparam int WAKE_W   = $clog2(WAKE_CYCLES + 1);
  localparam int SAMP_MAX = (SETTLE_SAMPLES > SHIFT_BLANK) ? SETTLE_SAMPLES : SHIFT_BLANK;
  localparam int SAMP_W   = $clog2(SAMP_MAX + 1);
  localparam int WIN_W    = $clog2(AGC_WINDOW);

  localparam logic [WAKE_W-1:0] WAKE_LAST   = WAKE_W'(WAKE_CYCLES - 1);
  localparam logic [SAMP_W-1:0] SETTLE_LAST = SAMP_W'(SETTLE_SAMPLES - 1);
  localparam logic [SAMP_W-1:0] BLANK_LAST  = SAMP_W'(SHIFT_BLANK - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(AGC_WINDOW - 1);
  localparam logic [14:0]       HI_LIM      = 15'(HI_THRESH);
  localparam logic [14:0]       LO_LIM      = 15'(LO_THRESH);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_WAKE   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_BLANK  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_mic_en;
  logic                r_dec_rst;
  logic [2:0]          r_shift;
  logic [WAKE_W-1:0]   r_wake_cnt;
  logic [SAMP_W-1:0]   r_samp_cnt;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [14:0]         r_peak;

  logic [1:0]          r_count;
  logic signed [15:0]  r_head;
  logic signed [15:0]  r_tail;
  logic                r_overflow;

  logic signed [15:0]  w_neg;
  logic [14:0]         w_mag;
  logic [14:0]         w_peak_next;
  logic                w_go_up;
  logic                w_go_dn;
  logic                w_flush;
  logic                w_push;
  logic                w_pop;

  // Sample magnitude; -32768 has no positive twin so it saturates to 32767.
  assign w_neg = -i_dec_pcm;
  always_comb begin
    w_mag = i_dec_pcm[14:0];
    if (i_dec_pcm[15]) begin
      if (i_dec_pcm[14:0] == 15'd0) w_mag = 15'h7FFF;
      else                          w_mag = w_neg[14:0];
    end
  end

  assign w_peak_next = (w_mag > r_peak) ? w_mag : r_peak;
  assign w_go_up = i_agc_en && (w_peak_next > HI_LIM) && (r_shift != 3'd7);
  assign w_go_dn = i_agc_en && (w_peak_next < LO_LIM) && (r_shift != 3'd0);

  // Sequencer: power-up, settle discard, AGC windows and post-shift blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_mic_en   <= 1'b0;
      r_dec_rst  <= 1'b1;
      r_shift    <= 3'd0;
      r_wake_cnt <= '0;
      r_samp_cnt <= '0;
      r_win_cnt  <= '0;
      r_peak     <= '0;
    end else if ((r_state != S_OFF) && !i_enable) begin
      r_state   <= S_OFF;
      r_mic_en  <= 1'b0;
      r_dec_rst <= 1'b1;
    end else begin
      case (r_state)
        S_OFF: begin
          if (i_enable) begin
            r_state    <= S_WAKE;
            r_mic_en   <= 1'b1;
            r_shift    <= i_init_shift;
            r_wake_cnt <= '0;
          end
        end
        S_WAKE: begin
          if (r_wake_cnt == WAKE_LAST) begin
            r_state    <= S_SETTLE;
            r_dec_rst  <= 1'b0;
            r_samp_cnt <= '0;
          end else begin
            r_wake_cnt <= r_wake_cnt + WAKE_W'(1);
          end
        end
        S_SETTLE: begin
          if (i_dec_pcm_valid) begin
            if (r_samp_cnt == SETTLE_LAST) begin
              r_state   <= S_RUN;
              r_win_cnt <= '0;
              r_peak    <= '0;
            end else begin
              r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
            end
          end
        end
        S_RUN: begin
          if (i_dec_pcm_valid) begin
            if (r_win_cnt == WIN_LAST) begin
              r_win_cnt <= '0;
              r_peak    <= '0;
              if (w_go_up) begin
                r_shift    <= r_shift + 3'd1;
                r_state    <= S_BLANK;
                r_samp_cnt <= '0;
              end else if (w_go_dn) begin
                r_shift    <= r_shift - 3'd1;
                r_state    <= S_BLANK;
                r_samp_cnt <= '0;
              end
            end else begin
              r_win_cnt <= r_win_cnt + WIN_W'(1);
              r_peak    <= w_peak_next;
            end
          end
        end
        S_BLANK: begin
          if (i_dec_pcm_valid) begin
            if (r_samp_cnt == BLANK_LAST) begin
              r_state   <= S_RUN;
              r_win_cnt <= '0;
              r_peak    <= '0;
            end else begin
              r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
            end
          end
        end
        default: begin
          r_state   <= S_OFF;
          r_mic_en  <= 1'b0;
          r_dec_rst <= 1'b1;
        end
      endcase
    end
  end

  // Anything leaving OFF-bound or sitting in OFF empties the FIFO silently.
  assign w_flush = (r_state == S_OFF) || !i_enable;
  assign w_push  = i_dec_pcm_valid && i_enable && (r_state == S_RUN);
  assign w_pop   = (r_count != 2'd0) && i_m_tready;

  // Two-entry output FIFO; head register drives m_tdata and holds when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= i_dec_pcm;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_tail  <= i_dec_pcm;
            r_count <= 2'd2;
          end else begin
            r_overflow <= 1'b1;
          end
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_dec_pcm;
          end else begin
            r_head <= r_tail;
            r_tail <= i_dec_pcm;
          end
        end
        2'b01: begin
          if (r_count == 2'd2) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_mic_en          = r_mic_en;
  assign o_dec_rst         = r_dec_rst;
  assign o_dec_scale_shift = r_shift;
  assign o_m_tdata         = r_head;
  assign o_m_tvalid        = (r_count != 2'd0);
  assign o_overflow        = r_overflow;
  assign o_state           = r_state;

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// tb_pdm_mic_ctrl: directed bench for pdm_mic_ctrl with a vector table for
// FIFO/backpressure behaviour and hand-written sequences for start-up,
// abort, AGC decisions and reset priority.
module tb_pdm_mic_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               agcEn = 1'b0;
  logic [2:0]         initShift = 3'd0;
  logic               micEn;
  logic               decRst;
  logic [2:0]         decShift;
  logic signed [15:0] decPcm = '0;
  logic               decValid = 1'b0;
  logic signed [15:0] mTdata;
  logic               mTvalid;
  logic               mTready = 1'b0;
  logic               overflow;
  logic [2:0]         state;

  int numVectors = 0;
  int numMiscompares = 0;

  typedef struct {
    logic               valid;
    logic signed [15:0] pcm;
    logic               ready;
    logic               expTvalid;
    logic signed [15:0] expTdata;
    logic               expOverflow;
  } vec_t;

  vec_t vecs[11];

  pdm_mic_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_enable          (enable),
    .i_agc_en          (agcEn),
    .i_init_shift      (initShift),
    .o_mic_en          (micEn),
    .o_dec_rst         (decRst),
    .o_dec_scale_shift (decShift),
    .i_dec_pcm         (decPcm),
    .i_dec_pcm_valid   (decValid),
    .o_m_tdata         (mTdata),
    .o_m_tvalid        (mTvalid),
    .i_m_tready        (mTready),
    .o_overflow        (overflow),
    .o_state           (state)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numVectors++;
    if (actual !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(actual), $signed(expected));
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are read 1 ns after the next one.
  task automatic applyStimulus(input logic en, input logic valid, input logic signed [15:0] pcm, input logic ready);
    enable   = en;
    decValid = valid;
    decPcm   = pcm;
    mTready  = ready;
    @(posedge clk);
    #1;
  endtask

  // Leave via OFF, then run WAKE and feed SETTLE until RUN is reached.
  task automatic bringUp(input logic [2:0] shift);
    initShift = shift;
    applyStimulus(1'b0, 1'b0, 16'sd0, 1'b1);
    for (int i = 0; i < 1200; i++) begin
      applyStimulus(1'b1, (state == 3'd2), 16'sd7, 1'b1);
      if (state == 3'd3) break;
    end
    checkOutput("bringUpState", 32'(state), 32'd3);
    checkOutput("bringUpShift", 32'(decShift), 32'(shift));
    checkOutput("bringUpOverflow", 32'(overflow), 32'd0);
  endtask

  // One AGC window of back-to-back samples with the sink always ready.
  task automatic runWindow(input int n, input logic signed [15:0] fill, input int spikeIdx,
                           input logic signed [15:0] spikeVal, input logic [2:0] expShift);
    logic signed [15:0] pcm;
    for (int i = 0; i < n; i++) begin
      pcm = (i == spikeIdx) ? spikeVal : fill;
      applyStimulus(1'b1, 1'b1, pcm, 1'b1);
      if (i == spikeIdx) begin
        checkOutput("spikeTvalid", 32'(mTvalid), 32'd1);
        checkOutput("spikeTdata", 32'(mTdata), 32'(spikeVal));
      end
      if (i == n - 2) begin
        checkOutput("windowMidState", 32'(state), 32'd3);
        checkOutput("windowMidShift", 32'(decShift), 32'(expShift));
      end
    end
  endtask

  // Four discarded samples after a shift change, then back to RUN.
  task automatic runBlank();
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, 1'b1, 16'(11 + b), 1'b1);
      checkOutput("blankState", 32'(state), (b < 3) ? 32'd4 : 32'd3);
      checkOutput("blankTvalid", 32'(mTvalid), 32'd0);
    end
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b1,  16'sd2000, 1'b0, 1'b1,  16'sd1234, 1'b0};
    vecs[1]  = '{1'b1,  16'sd3000, 1'b0, 1'b1,  16'sd1234, 1'b1};
    vecs[2]  = '{1'b0,  16'sd0,    1'b1, 1'b1,  16'sd2000, 1'b1};
    vecs[3]  = '{1'b0,  16'sd0,    1'b1, 1'b0,  16'sd2000, 1'b1};
    vecs[4]  = '{1'b0,  16'sd0,    1'b1, 1'b0,  16'sd2000, 1'b1};
    vecs[5]  = '{1'b1, -16'sd500,  1'b0, 1'b1, -16'sd500,  1'b1};
    vecs[6]  = '{1'b1,  16'sd600,  1'b1, 1'b1,  16'sd600,  1'b1};
    vecs[7]  = '{1'b1,  16'sd700,  1'b0, 1'b1,  16'sd600,  1'b1};
    vecs[8]  = '{1'b1,  16'sd800,  1'b1, 1'b1,  16'sd700,  1'b1};
    vecs[9]  = '{1'b0,  16'sd0,    1'b1, 1'b1,  16'sd800,  1'b1};
    vecs[10] = '{1'b0,  16'sd0,    1'b1, 1'b0,  16'sd800,  1'b1};

    $display("[TB] reset");
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'sd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'sd0, 1'b0);
    checkOutput("rstState", 32'(state), 32'd0);
    checkOutput("rstMicEn", 32'(micEn), 32'd0);
    checkOutput("rstDecRst", 32'(decRst), 32'd1);
    checkOutput("rstShift", 32'(decShift), 32'd0);
    checkOutput("rstTvalid", 32'(mTvalid), 32'd0);
    checkOutput("rstTdata", 32'(mTdata), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    $display("[TB] start-up");
    agcEn = 1'b0;
    initShift = 3'd3;
    n = 0;
    for (int i = 1; i <= 1100; i++) begin
      applyStimulus(1'b1, 1'b0, 16'sd0, 1'b0);
      if (i == 1) begin
        checkOutput("wakeState", 32'(state), 32'd1);
        checkOutput("wakeMicEn", 32'(micEn), 32'd1);
        checkOutput("wakeDecRst", 32'(decRst), 32'd1);
      end
      n = i;
      if (decRst == 1'b0) break;
    end
    checkOutput("wakeLength", 32'(n), 32'd1001);
    checkOutput("settleState", 32'(state), 32'd2);
    checkOutput("settleShift", 32'(decShift), 32'd3);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b1, 16'(1000 + k), 1'b0);
      checkOutput("settleDiscard", 32'(mTvalid), 32'd0);
      applyStimulus(1'b1, 1'b0, 16'sd0, 1'b0);
    end
    checkOutput("runEntered", 32'(state), 32'd3);
    applyStimulus(1'b1, 1'b1, 16'sd1234, 1'b0);
    checkOutput("firstTvalid", 32'(mTvalid), 32'd1);
    checkOutput("firstTdata", 32'(mTdata), 32'sd1234);
    checkOutput("firstShift", 32'(decShift), 32'd3);

    $display("[TB] FIFO vector table");
    for (int v = 0; v < 11; v++) begin
      applyStimulus(1'b1, vecs[v].valid, vecs[v].pcm, vecs[v].ready);
      checkOutput($sformatf("vec%0d.tvalid", v), 32'(mTvalid), 32'(vecs[v].expTvalid));
      checkOutput($sformatf("vec%0d.tdata", v), 32'(mTdata), 32'(vecs[v].expTdata));
      checkOutput($sformatf("vec%0d.overflow", v), 32'(overflow), 32'(vecs[v].expOverflow));
      checkOutput($sformatf("vec%0d.state", v), 32'(state), 32'd3);
    end

    $display("[TB] abort in RUN");
    applyStimulus(1'b1, 1'b1, 16'sd900, 1'b0);
    checkOutput("preAbortTvalid", 32'(mTvalid), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'sd55, 1'b0);
    checkOutput("abortRunState", 32'(state), 32'd0);
    checkOutput("abortRunMicEn", 32'(micEn), 32'd0);
    checkOutput("abortRunDecRst", 32'(decRst), 32'd1);
    checkOutput("abortRunTvalid", 32'(mTvalid), 32'd0);
    checkOutput("abortRunOverflow", 32'(overflow), 32'd0);

    $display("[TB] abort in SETTLE");
    for (int i = 0; i < 1100; i++) begin
      applyStimulus(1'b1, 1'b0, 16'sd0, 1'b1);
      if (state == 3'd2) break;
    end
    checkOutput("reachSettle", 32'(state), 32'd2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 16'(k), 1'b1);
      checkOutput("midSettleState", 32'(state), 32'd2);
    end
    applyStimulus(1'b0, 1'b1, 16'sd5, 1'b1);
    checkOutput("abortSettleState", 32'(state), 32'd0);
    checkOutput("abortSettleMicEn", 32'(micEn), 32'd0);
    checkOutput("abortSettleDecRst", 32'(decRst), 32'd1);
    checkOutput("abortSettleTvalid", 32'(mTvalid), 32'd0);

    $display("[TB] simultaneous push/pop on full FIFO");
    agcEn = 1'b0;
    bringUp(3'd3);
    applyStimulus(1'b1, 1'b1, 16'sd11, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'sd22, 1'b0);
    checkOutput("fullHead", 32'(mTdata), 32'sd11);
    applyStimulus(1'b1, 1'b1, 16'sd33, 1'b1);
    checkOutput("pushPopHead", 32'(mTdata), 32'sd22);
    checkOutput("pushPopOverflow", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'sd0, 1'b1);
    checkOutput("pushPopTail", 32'(mTdata), 32'sd33);
    checkOutput("pushPopTailValid", 32'(mTvalid), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'sd0, 1'b1);
    checkOutput("drainedTvalid", 32'(mTvalid), 32'd0);
    checkOutput("drainedOverflow", 32'(overflow), 32'd0);

    $display("[TB] AGC up");
    agcEn = 1'b1;
    bringUp(3'd2);
    runWindow(256, 16'sd100, 99, -16'sd30000, 3'd2);
    checkOutput("agcUpState", 32'(state), 32'd4);
    checkOutput("agcUpShift", 32'(decShift), 32'd3);
    checkOutput("agcUpLastTdata", 32'(mTdata), 32'sd100);
    runBlank();
    applyStimulus(1'b1, 1'b1, 16'sd555, 1'b1);
    checkOutput("postBlankTvalid", 32'(mTvalid), 32'd1);
    checkOutput("postBlankTdata", 32'(mTdata), 32'sd555);
    checkOutput("postBlankState", 32'(state), 32'd3);
    checkOutput("postBlankShift", 32'(decShift), 32'd3);

    $display("[TB] AGC floor at shift 0");
    bringUp(3'd0);
    runWindow(256, 16'sd100, -1, 16'sd0, 3'd0);
    checkOutput("floorState", 32'(state), 32'd3);
    checkOutput("floorShift", 32'(decShift), 32'd0);

    $display("[TB] AGC ceiling at shift 7");
    bringUp(3'd7);
    runWindow(256, 16'sd5000, 10, -16'sd32768, 3'd7);
    checkOutput("ceilState", 32'(state), 32'd3);
    checkOutput("ceilShift", 32'(decShift), 32'd7);

    $display("[TB] AGC from shift 5");
    bringUp(3'd5);
    runWindow(256, 16'sd5000, 200, -16'sd32768, 3'd5);
    checkOutput("minNegUpState", 32'(state), 32'd4);
    checkOutput("minNegUpShift", 32'(decShift), 32'd6);
    runBlank();
    runWindow(256, 16'sd100, -1, 16'sd0, 3'd6);
    checkOutput("agcDownState", 32'(state), 32'd4);
    checkOutput("agcDownShift", 32'(decShift), 32'd5);
    runBlank();
    agcEn = 1'b0;
    runWindow(256, 16'sd100, -1, 16'sd0, 3'd5);
    checkOutput("frozenState", 32'(state), 32'd3);
    checkOutput("frozenShift", 32'(decShift), 32'd5);
    agcEn = 1'b1;
    runWindow(256, 16'sd24576, -1, 16'sd0, 3'd5);
    checkOutput("atHiState", 32'(state), 32'd3);
    checkOutput("atHiShift", 32'(decShift), 32'd5);
    runWindow(256, 16'sd4096, -1, 16'sd0, 3'd5);
    checkOutput("atLoState", 32'(state), 32'd3);
    checkOutput("atLoShift", 32'(decShift), 32'd5);

    $display("[TB] reset priority");
    applyStimulus(1'b1, 1'b1, 16'sd4321, 1'b0);
    checkOutput("preRstTvalid", 32'(mTvalid), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'sd99, 1'b0);
    checkOutput("midRstState", 32'(state), 32'd0);
    checkOutput("midRstTvalid", 32'(mTvalid), 32'd0);
    checkOutput("midRstTdata", 32'(mTdata), 32'd0);
    checkOutput("midRstShift", 32'(decShift), 32'd0);
    checkOutput("midRstDecRst", 32'(decRst), 32'd1);
    checkOutput("midRstOverflow", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
